// File: rtl/filter_pkg.sv
// -----------------------------------------------------------------------------
// filter_pkg
// Purpose : Shared constants and types for the filter sample-capture block.
//           Holds the default sample width, the capture depth and the state
//           encoding used by the capture controller.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package filter_pkg;

    // Default width of one filter output sample (two's complement).
    localparam int SAMPLE_W      = 16;

    // Default number of samples stored per capture.
    localparam int CAPTURE_DEPTH = 100;

    // Capture controller states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP    = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } capture_state_t;

endpackage

// File: rtl/capture_ram.sv
// -----------------------------------------------------------------------------
// capture_ram
// Purpose : Simple dual-port sample store. It has one write port and one
//           registered read port. Storage is not reset, so it maps onto block
//           RAM.
// Ports   :
//   i_clk      - clock, all accesses on rising edge
//   i_wr_en    - write strobe
//   i_wr_addr  - write index
//   i_wr_data  - sample to store
//   i_rd_en    - read strobe; o_rd_data only updates when this is high
//   i_rd_addr  - read index
//   o_rd_data  - registered read data, holds between reads
// -----------------------------------------------------------------------------
module capture_ram
    import filter_pkg::*;
#(
    parameter int WIDTH  = SAMPLE_W,
    parameter int DEPTH  = CAPTURE_DEPTH,
    parameter int ADDR_W = 7
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Write port. The caller only writes indices below DEPTH.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port. It holds its last value when there is no read,
    // so the top level gets "hold" behaviour for free.
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sample_capture.sv
// -----------------------------------------------------------------------------
// sample_capture
// Purpose : Captures DEPTH filter output samples after discarding a
//           programmable number of settling samples. It tracks the signed
//           peak max/min of the captured samples and lets software read the
//           stored samples at any time, including during a capture.
// Ports   :
//   clk       - single clock
//   reset     - asynchronous, active-low reset
//   in_valid  - in_data carries a sample this cycle
//   in_data   - signed filter sample
//   start     - single-cycle capture request (ignored while busy)
//   skip      - settling samples to discard, sampled on start
//   busy      - high while skipping or capturing
//   done      - high once DEPTH samples are stored
//   count     - samples stored in the current capture
//   rd_en     - readout request
//   rd_addr   - readout index
//   rd_data   - stored sample, one cycle after an accepted request
//   rd_valid  - rd_data was refreshed by an accepted request
//   peak_max  - signed maximum of the captured samples
//   peak_min  - signed minimum of the captured samples
// -----------------------------------------------------------------------------
module sample_capture
    import filter_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = CAPTURE_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             start,
    input  logic [7:0]       skip,
    output logic             busy,
    output logic             done,
    output logic [6:0]       count,
    input  logic             rd_en,
    input  logic [6:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [WIDTH-1:0] peak_max,
    output logic [WIDTH-1:0] peak_min
);

    localparam logic [6:0]       LAST_IDX = 7'(DEPTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

    capture_state_t   r_state;
    capture_state_t   w_next_state;
    logic [7:0]       r_skip_cnt;
    logic [6:0]       r_count;
    logic [WIDTH-1:0] r_peak_max;
    logic [WIDTH-1:0] r_peak_min;
    logic             r_rd_valid;
    logic             r_rd_zero;
    logic             w_start_ok;
    logic             w_wr;
    logic             w_rd_hit;
    logic [WIDTH-1:0] w_ram_q;

    // A start is only accepted when no capture is in progress.
    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_wr       = (r_state == CAPTURE) && in_valid;
    // Reads at or beyond count are refused. This also means a read can never
    // hit the slot being written in the same cycle.
    assign w_rd_hit   = rd_en && (rd_addr < r_count);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next_state = (skip != 8'd0) ? SKIP : CAPTURE;
                end
            end
            SKIP: begin
                if (in_valid && (r_skip_cnt == 8'd1)) begin
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (in_valid && (r_count == LAST_IDX)) begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Status outputs, decoded straight from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            SKIP, CAPTURE: busy = 1'b1;
            DONE:          done = 1'b1;
            default:       ;
        endcase
    end

    // Capture datapath. A start primes the peaks with opposite extremes, so
    // the first stored sample always becomes both max and min.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count    <= 7'd0;
            r_skip_cnt <= 8'd0;
            r_peak_max <= '0;
            r_peak_min <= '0;
        end else if (w_start_ok) begin
            r_count    <= 7'd0;
            r_skip_cnt <= skip;
            r_peak_max <= MOST_NEG;
            r_peak_min <= MOST_POS;
        end else begin
            if ((r_state == SKIP) && in_valid) begin
                r_skip_cnt <= r_skip_cnt - 8'd1;
            end
            if (w_wr) begin
                r_count <= r_count + 7'd1;
                if ($signed(in_data) > $signed(r_peak_max)) begin
                    r_peak_max <= in_data;
                end
                if ($signed(in_data) < $signed(r_peak_min)) begin
                    r_peak_min <= in_data;
                end
            end
        end
    end

    // Readout control. The RAM output register has no reset, so r_rd_zero
    // masks it to zero after reset until the first accepted read reloads it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_valid <= 1'b0;
            r_rd_zero  <= 1'b1;
        end else begin
            r_rd_valid <= w_rd_hit;
            if (w_rd_hit) begin
                r_rd_zero <= 1'b0;
            end
        end
    end

    capture_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (7)
    ) u_ram (
        .i_clk     (clk),
        .i_wr_en   (w_wr),
        .i_wr_addr (r_count),
        .i_wr_data (in_data),
        .i_rd_en   (w_rd_hit),
        .i_rd_addr (rd_addr),
        .o_rd_data (w_ram_q)
    );

    assign count    = r_count;
    assign peak_max = r_peak_max;
    assign peak_min = r_peak_min;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_zero ? '0 : w_ram_q;

endmodule

// File: tb/tb_sample_capture.sv
// -----------------------------------------------------------------------------
// tb_sample_capture
// Purpose : Directed bench for sample_capture. It uses a table of per-cycle
//           vectors for the skip/readout/peak cases, plus hand-written
//           sequences for reset abort, a full capture, ignored start,
//           behaviour in DONE, and restart.
// -----------------------------------------------------------------------------
module tb_sample_capture;

    logic        clk;
    logic        reset;
    logic        inValid;
    logic [15:0] inData;
    logic        start;
    logic [7:0]  skip;
    logic        busy;
    logic        done;
    logic [6:0]  count;
    logic        rdEn;
    logic [6:0]  rdAddr;
    logic [15:0] rdData;
    logic        rdValid;
    logic [15:0] peakMax;
    logic [15:0] peakMin;

    int numChecks = 0;
    int numFails  = 0;

    typedef struct {
        logic        start;
        logic [7:0]  skip;
        logic        inValid;
        logic [15:0] inData;
        logic        rdEn;
        logic [6:0]  rdAddr;
        logic        expBusy;
        logic        expDone;
        logic [6:0]  expCount;
        logic        expRdValid;
        logic [15:0] expRdData;
        logic [15:0] expMax;
        logic [15:0] expMin;
    } vec_t;

    vec_t vecs [17];

    sample_capture #(
        .WIDTH (16),
        .DEPTH (100)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (inValid),
        .in_data  (inData),
        .start    (start),
        .skip     (skip),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .rd_en    (rdEn),
        .rd_addr  (rdAddr),
        .rd_data  (rdData),
        .rd_valid (rdValid),
        .peak_max (peakMax),
        .peak_min (peakMin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and log a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        numChecks++;
        if (act !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample the outputs just after the edge.
    task automatic applyStimulus(input logic st, input logic [7:0] sk, input logic iv,
                                 input logic [15:0] d, input logic re, input logic [6:0] ra);
        start   = st;
        skip    = sk;
        inValid = iv;
        inData  = d;
        rdEn    = re;
        rdAddr  = ra;
        @(posedge clk);
        #1;
    endtask

    // Run a slice of the vector table.
    task automatic runRange(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            applyStimulus(vecs[k].start, vecs[k].skip, vecs[k].inValid,
                          vecs[k].inData, vecs[k].rdEn, vecs[k].rdAddr);
            checkOutput($sformatf("vec%0d_busy", k),    16'(busy),    16'(vecs[k].expBusy));
            checkOutput($sformatf("vec%0d_done", k),    16'(done),    16'(vecs[k].expDone));
            checkOutput($sformatf("vec%0d_count", k),   16'(count),   16'(vecs[k].expCount));
            checkOutput($sformatf("vec%0d_rdvalid", k), 16'(rdValid), 16'(vecs[k].expRdValid));
            checkOutput($sformatf("vec%0d_rddata", k),  rdData,       vecs[k].expRdData);
            checkOutput($sformatf("vec%0d_max", k),     peakMax,      vecs[k].expMax);
            checkOutput($sformatf("vec%0d_min", k),     peakMin,      vecs[k].expMin);
        end
    endtask

    // Pulse reset between edges and release it before the next edge.
    task automatic pulseReset();
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        // Table part A: skip=3, samples 10..14, reads, then an ignored start.
        //            st    skip  iv    data        re    ra     busy  done  cnt   rdv   rdd         max         min
        vecs[0]  = '{1'b1, 8'd3, 1'b0, 16'd0,      1'b0, 7'd0,  1'b1, 1'b0, 7'd0, 1'b0, 16'h0000,   16'h8000,   16'h7FFF};
        vecs[1]  = '{1'b0, 8'd0, 1'b1, 16'd10,     1'b0, 7'd0,  1'b1, 1'b0, 7'd0, 1'b0, 16'h0000,   16'h8000,   16'h7FFF};
        vecs[2]  = '{1'b0, 8'd0, 1'b1, 16'd11,     1'b0, 7'd0,  1'b1, 1'b0, 7'd0, 1'b0, 16'h0000,   16'h8000,   16'h7FFF};
        vecs[3]  = '{1'b0, 8'd0, 1'b1, 16'd12,     1'b0, 7'd0,  1'b1, 1'b0, 7'd0, 1'b0, 16'h0000,   16'h8000,   16'h7FFF};
        vecs[4]  = '{1'b0, 8'd0, 1'b1, 16'd13,     1'b0, 7'd0,  1'b1, 1'b0, 7'd1, 1'b0, 16'h0000,   16'd13,     16'd13};
        vecs[5]  = '{1'b0, 8'd0, 1'b1, 16'd14,     1'b1, 7'd0,  1'b1, 1'b0, 7'd2, 1'b1, 16'd13,     16'd14,     16'd13};
        vecs[6]  = '{1'b0, 8'd0, 1'b0, 16'd0,      1'b1, 7'd5,  1'b1, 1'b0, 7'd2, 1'b0, 16'd13,     16'd14,     16'd13};
        vecs[7]  = '{1'b0, 8'd0, 1'b1, 16'hFFFB,   1'b1, 7'd1,  1'b1, 1'b0, 7'd3, 1'b1, 16'd14,     16'd14,     16'hFFFB};
        vecs[8]  = '{1'b1, 8'd0, 1'b0, 16'd0,      1'b0, 7'd0,  1'b1, 1'b0, 7'd3, 1'b0, 16'd14,     16'd14,     16'hFFFB};
        // Table part B: extremes with gaps, then reads in and out of range.
        vecs[9]  = '{1'b1, 8'd0, 1'b0, 16'd0,      1'b0, 7'd0,  1'b1, 1'b0, 7'd0, 1'b0, 16'h0000,   16'h8000,   16'h7FFF};
        vecs[10] = '{1'b0, 8'd0, 1'b1, 16'h8000,   1'b0, 7'd0,  1'b1, 1'b0, 7'd1, 1'b0, 16'h0000,   16'h8000,   16'h8000};
        vecs[11] = '{1'b0, 8'd0, 1'b0, 16'h1234,   1'b0, 7'd0,  1'b1, 1'b0, 7'd1, 1'b0, 16'h0000,   16'h8000,   16'h8000};
        vecs[12] = '{1'b0, 8'd0, 1'b1, 16'd5,      1'b0, 7'd0,  1'b1, 1'b0, 7'd2, 1'b0, 16'h0000,   16'd5,      16'h8000};
        vecs[13] = '{1'b0, 8'd0, 1'b0, 16'd0,      1'b1, 7'd0,  1'b1, 1'b0, 7'd2, 1'b1, 16'h8000,   16'd5,      16'h8000};
        vecs[14] = '{1'b0, 8'd0, 1'b1, 16'h7FFF,   1'b0, 7'd0,  1'b1, 1'b0, 7'd3, 1'b0, 16'h8000,   16'h7FFF,   16'h8000};
        vecs[15] = '{1'b0, 8'd0, 1'b0, 16'd0,      1'b1, 7'd2,  1'b1, 1'b0, 7'd3, 1'b1, 16'h7FFF,   16'h7FFF,   16'h8000};
        vecs[16] = '{1'b0, 8'd0, 1'b0, 16'd0,      1'b1, 7'd3,  1'b1, 1'b0, 7'd3, 1'b0, 16'h7FFF,   16'h7FFF,   16'h8000};

        reset   = 1'b0;
        start   = 1'b0;
        skip    = 8'd0;
        inValid = 1'b0;
        inData  = 16'd0;
        rdEn    = 1'b0;
        rdAddr  = 7'd0;

        // Reset state while reset is held.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy",    16'(busy),    16'd0);
        checkOutput("rst_done",    16'(done),    16'd0);
        checkOutput("rst_count",   16'(count),   16'd0);
        checkOutput("rst_rdvalid", 16'(rdValid), 16'd0);
        checkOutput("rst_rddata",  rdData,       16'd0);
        checkOutput("rst_max",     peakMax,      16'd0);
        checkOutput("rst_min",     peakMin,      16'd0);
        reset = 1'b1;

        runRange(0, 8);

        // Continue capturing up to count=40, then abort with reset.
        for (int i = 3; i < 40; i++) begin
            applyStimulus(1'b0, 8'd0, 1'b1, 16'(100 + i), 1'b0, 7'd0);
        end
        checkOutput("pre_abort_count", 16'(count), 16'd40);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort_count",   16'(count),   16'd0);
        checkOutput("abort_busy",    16'(busy),    16'd0);
        checkOutput("abort_done",    16'(done),    16'd0);
        checkOutput("abort_rddata",  rdData,       16'd0);
        checkOutput("abort_max",     peakMax,      16'd0);
        @(negedge clk);
        reset = 1'b1;
        // Samples without a start must be ignored.
        applyStimulus(1'b0, 8'd0, 1'b1, 16'd77, 1'b0, 7'd0);
        checkOutput("nostart_count", 16'(count), 16'd0);
        checkOutput("nostart_busy",  16'(busy),  16'd0);

        runRange(9, 16);

        // Full capture of 0..99 with reads and an ignored start along the way.
        pulseReset();
        applyStimulus(1'b1, 8'd0, 1'b0, 16'd0, 1'b0, 7'd0);
        checkOutput("full_start_busy", 16'(busy), 16'd1);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(i == 60, 8'd0, 1'b1, 16'(i),
                          (i == 20) || (i == 21), (i == 20) ? 7'd50 : 7'd19);
            checkOutput($sformatf("full_count%0d", i), 16'(count), 16'(i + 1));
            if (i == 20) checkOutput("read50_rdvalid", 16'(rdValid), 16'd0);
            if (i == 21) begin
                checkOutput("read19_rdvalid", 16'(rdValid), 16'd1);
                checkOutput("read19_rddata",  rdData,       16'd19);
            end
            if (i == 60) checkOutput("ignstart_busy", 16'(busy), 16'd1);
            if (i == 98) checkOutput("full_done98",   16'(done), 16'd0);
        end
        checkOutput("full_done",  16'(done), 16'd1);
        checkOutput("full_busy",  16'(busy), 16'd0);
        checkOutput("full_max",   peakMax,   16'd99);
        checkOutput("full_min",   peakMin,   16'd0);

        // Samples in DONE are ignored. Data is intact after the ignored start.
        applyStimulus(1'b0, 8'd0, 1'b1, 16'd500, 1'b1, 7'd99);
        checkOutput("done_ign_count", 16'(count),   16'd100);
        checkOutput("done_ign_max",   peakMax,      16'd99);
        checkOutput("read99_rdvalid", 16'(rdValid), 16'd1);
        checkOutput("read99_rddata",  rdData,       16'd99);
        applyStimulus(1'b0, 8'd0, 1'b0, 16'd0, 1'b1, 7'd60);
        checkOutput("read60_rddata",  rdData,       16'd60);
        applyStimulus(1'b0, 8'd0, 1'b0, 16'd0, 1'b1, 7'd100);
        checkOutput("read100_rdvalid", 16'(rdValid), 16'd0);
        checkOutput("read100_rddata",  rdData,       16'd60);

        // Restart from DONE.
        applyStimulus(1'b1, 8'd0, 1'b0, 16'd0, 1'b0, 7'd0);
        checkOutput("restart_done",  16'(done),  16'd0);
        checkOutput("restart_busy",  16'(busy),  16'd1);
        checkOutput("restart_count", 16'(count), 16'd0);
        checkOutput("restart_max",   peakMax,    16'h8000);
        checkOutput("restart_min",   peakMin,    16'h7FFF);
        applyStimulus(1'b0, 8'd0, 1'b1, 16'd7, 1'b0, 7'd0);
        checkOutput("restart_count1", 16'(count), 16'd1);
        applyStimulus(1'b0, 8'd0, 1'b0, 16'd0, 1'b1, 7'd0);
        checkOutput("restart_rd0", rdData, 16'd7);
        applyStimulus(1'b0, 8'd0, 1'b0, 16'd0, 1'b1, 7'd1);
        checkOutput("restart_rd1_valid", 16'(rdValid), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
